master_interface: RTL
=====================

// Module: master_interface
// PURPOSE
//   Transmit end of the valid/ready point-to-point link. Accepts words from a
//   local producer (en/data/busy), buffers them in a DEPTH-entry FIFO plus one
//   output register, and presents them to the slave side as o_master_valid /
//   o_master_data, releasing each word on a shake (valid & ready).
// PARAMETERS
//   DATA_W  32  width of data word
//   DEPTH   4   FIFO entries behind the output register; power of 2, >= 2
// PORTS
//   clk                 in   1        clock, all state on rising edge
//   rst_n               in   1        asynchronous active-low reset
//   i_master_en         in   1        producer write strobe, one word per cycle
//   i_master_data       in   DATA_W   producer write data
//   o_master_busy       out  1        FIFO full; writes this cycle are dropped
//   o_master_valid      out  1        word on o_master_data is valid (registered)
//   o_master_data       out  DATA_W   word to slave (registered)
//   i_master_ready      in   1        slave ready; shake = valid & ready
//   o_master_level      out  $clog2(DEPTH+2)  words held: FIFO count + valid
//   o_master_overflow   out  1        sticky: write attempted while busy
// BEHAVIOUR
//   Reset (async, rst_n=0): valid=0, data=0, busy=0, level=0, overflow=0,
//     FIFO pointers/count=0. Release takes effect on next clk edge.
//   shake = o_master_valid & i_master_ready; slot_free = !o_master_valid | shake.
//   o_master_busy = (fifo_count == DEPTH); combinational from registers only,
//     never from i_master_ready (no ready-to-busy combinational path).
//   Write accepted = i_master_en & !o_master_busy. Dropped write sets overflow;
//     FIFO and output unchanged by it. Full + shake same cycle: write still
//     dropped (busy reflects start-of-cycle state).
//   Output register load, per cycle, when slot_free:
//     - FIFO non-empty: load FIFO head, pop; accepted write pushes to FIFO tail
//       (simultaneous push/pop, count unchanged).
//     - FIFO empty & write accepted: bypass, load write data directly
//       (latency 1: en at edge N -> valid high after edge N).
//     - else: valid <= 0 (data holds last value).
//   When !slot_free: output holds; accepted write pushes to FIFO.
//   Protocol: once valid=1, valid and data stay stable until shake. valid never
//     depends combinationally on ready. Back-to-back shakes sustain 1 word/cycle.
//   Ordering: strict FIFO order; no word lost or duplicated unless dropped on busy.
//   Pointers: log2(DEPTH) bits, natural wrap; count 0..DEPTH separate register.
//   o_master_level = fifo_count + o_master_valid, range 0..DEPTH+1.
//   Reset mid-transfer: all buffered words discarded, valid drops immediately.
// TESTING
//   1 Reset: rst_n=0 mid-stream with 3 words held -> valid=0, level=0,
//     overflow=0 asynchronously; first write after release appears 1 cycle later.
//   2 Bypass: ready=1, write 0xA5A5_0001 on empty -> valid=1 data=0xA5A5_0001
//     next cycle, shake, valid=0 after; level 0->1->0.
//   3 Backpressure: ready=0, write 0x10..0x15 (6 words, DEPTH=4) -> first 5
//     held, level=5, busy=1 after 5th, 6th dropped, overflow=1; data stays 0x10.
//   4 Drain: from test 3 raise ready=1 -> 0x10..0x14 out on 5 consecutive
//     cycles in order, busy clears after first shake, overflow stays 1.
//   5 Streaming: ready=1, en=1 continuous 100 cycles, incrementing data ->
//     100 shakes, in order, level<=1, busy never asserted.
//   6 Random ready/en (10k cycles) with scoreboard -> order preserved, valid/data
//     stable while valid&!ready, dropped words only when busy=1.

Source files
------------

// File: rtl/master_interface.sv
// Transmit end of a valid/ready link: producer words are buffered in a small
// FIFO behind a registered output stage and released to the slave on each shake.
module master_interface #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_master_en,
    input  logic [DATA_W-1:0]             i_master_data,
    output logic                          o_master_busy,
    output logic                          o_master_valid,
    output logic [DATA_W-1:0]             o_master_data,
    input  logic                          i_master_ready,
    output logic [$clog2(DEPTH+2)-1:0]    o_master_level,
    output logic                          o_master_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(DEPTH + 2);

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;

    logic fifo_full;
    logic fifo_empty;
    logic shake;
    logic slot_free;
    logic wr_accept;
    logic pop;
    logic bypass;
    logic push;

    // Busy is derived from registered state only, so ready never reaches busy
    // combinationally; a full FIFO drops the write even if a shake frees space.
    always_comb begin
        fifo_full  = (fifo_count == CW'(DEPTH));
        fifo_empty = (fifo_count == '0);
        shake      = o_master_valid & i_master_ready;
        slot_free  = ~o_master_valid | shake;
        wr_accept  = i_master_en & ~fifo_full;
        pop        = slot_free & ~fifo_empty;
        bypass     = slot_free & fifo_empty & wr_accept;
        push       = wr_accept & ~bypass;
    end

    assign o_master_busy  = fifo_full;
    assign o_master_level = LW'(fifo_count) + LW'(o_master_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage array needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_master_data;
        end
    end

    // Output stage reloads only when it is empty or being consumed this cycle,
    // which keeps valid/data stable while the slave stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_master_valid <= 1'b0;
            o_master_data  <= '0;
        end else if (slot_free) begin
            if (pop) begin
                o_master_valid <= 1'b1;
                o_master_data  <= fifo_mem[rd_ptr];
            end else if (bypass) begin
                o_master_valid <= 1'b1;
                o_master_data  <= i_master_data;
            end else begin
                o_master_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_master_overflow <= 1'b0;
        end else if (i_master_en && fifo_full) begin
            o_master_overflow <= 1'b1;
        end
    end

endmodule
